// File: rtl/tile_packet_encoder.sv
// Tile packet encoder: per job streams addr, optional zoom, real/imag limbs and a start word,
// then pulses end-of-stream. Define TILE_ENC_ZOOM_EN to emit the tag-1 zoom word.
module tile_packet_encoder #(
    parameter int unsigned LIMB_INDEX_BITS = 6,
    parameter int unsigned LIMB_SIZE_BITS  = 27
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       limb_wr_real_en,
    input  logic                       limb_wr_imag_en,
    input  logic [LIMB_INDEX_BITS-1:0] limb_wr_index,
    input  logic [LIMB_SIZE_BITS-1:0]  limb_wr_data,
    input  logic [28:0]                job_addr,
    input  logic [28:0]                job_zoom,
    input  logic [LIMB_INDEX_BITS:0]   job_num_limbs,
    input  logic                       job_valid,
    output logic                       job_ready,
    output logic [31:0]                out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_end_of_stream,
    output logic [15:0]                packets_sent
);
    localparam int unsigned Depth = 2 ** LIMB_INDEX_BITS;
    localparam logic [LIMB_INDEX_BITS:0]   NumOne = (LIMB_INDEX_BITS + 1)'(1);
    localparam logic [LIMB_INDEX_BITS-1:0] IdxOne = LIMB_INDEX_BITS'(1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StZoom,
        StReal,
        StImag,
        StStart,
        StEos
    } state_e;

    state_e                     state_q, state_d;
    logic [LIMB_INDEX_BITS-1:0] cnt_q, cnt_d;
    logic [LIMB_INDEX_BITS:0]   nlimbs_q, nlimbs_d;
    logic [31:0]                out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic                       eos_q, eos_d;
    logic [15:0]                packets_q, packets_d;

    logic                       xfer;
    logic                       enter_limbs;
    logic                       is_last;
    logic                       fetch_last;
    logic [LIMB_INDEX_BITS:0]   last_idx;
    logic                       wr_ok;

    logic [LIMB_SIZE_BITS-1:0]  real_mem [Depth];
    logic [LIMB_SIZE_BITS-1:0]  imag_mem [Depth];
    logic [LIMB_SIZE_BITS-1:0]  rd_data_q;
    logic [28:0]                limb_ext;
    logic                       fetch_imag;
    logic [LIMB_INDEX_BITS-1:0] fetch_idx;
    logic                       bypass;

`ifdef TILE_ENC_ZOOM_EN
    logic [28:0] zoom_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            zoom_q <= '0;
        end else if (state_q == StIdle && job_valid) begin
            zoom_q <= job_zoom;
        end
    end
`else
    logic unused_zoom;
    assign unused_zoom = ^job_zoom;
`endif

    assign wr_ok     = (state_q == StIdle);
    assign job_ready = (state_q == StIdle);
    assign xfer      = out_valid_q && out_ready;
    assign last_idx  = nlimbs_q - NumOne;
    assign is_last   = ({1'b0, cnt_q} == last_idx);
    assign fetch_last = ({1'b0, cnt_d} == last_idx);
    assign limb_ext  = 29'(rd_data_q);

    always_ff @(posedge clock) begin
        if (wr_ok && limb_wr_real_en) begin
            real_mem[limb_wr_index] <= limb_wr_data;
        end
        if (wr_ok && limb_wr_imag_en) begin
            imag_mem[limb_wr_index] <= limb_wr_data;
        end
    end

    // Read-ahead: rd_data_q always holds the limb that the next transfer will load.
    always_comb begin
        fetch_imag = 1'b0;
        fetch_idx  = '0;
        if (state_d == StReal) begin
            if (fetch_last) begin
                fetch_imag = 1'b1;
            end else begin
                fetch_idx = cnt_d + IdxOne;
            end
        end else if (state_d == StImag) begin
            fetch_imag = 1'b1;
            fetch_idx  = cnt_d + IdxOne;
        end
    end

    // A write landing on the same edge as a job accept must still be seen by the first limb.
    assign bypass = wr_ok && (limb_wr_index == fetch_idx) &&
                    (fetch_imag ? limb_wr_imag_en : limb_wr_real_en);

    always_ff @(posedge clock) begin
        if (bypass) begin
            rd_data_q <= limb_wr_data;
        end else begin
            rd_data_q <= fetch_imag ? imag_mem[fetch_idx] : real_mem[fetch_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nlimbs_d    = nlimbs_q;
        out_data_d  = out_data_q;
        packets_d   = packets_q;
        enter_limbs = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (job_valid) begin
                    state_d    = StAddr;
                    nlimbs_d   = job_num_limbs;
                    out_data_d = {3'd0, job_addr};
                end
            end
            StAddr: begin
                if (xfer) begin
`ifdef TILE_ENC_ZOOM_EN
                    state_d    = StZoom;
                    out_data_d = {3'd1, zoom_q};
`else
                    enter_limbs = 1'b1;
`endif
                end
            end
            StZoom: begin
                if (xfer) begin
                    enter_limbs = 1'b1;
                end
            end
            StReal: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d    = StImag;
                        cnt_d      = '0;
                        out_data_d = {3'd3, limb_ext};
                    end else begin
                        cnt_d      = cnt_q + IdxOne;
                        out_data_d = {3'd2, limb_ext};
                    end
                end
            end
            StImag: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d    = StStart;
                        out_data_d = {3'd4, 29'd0};
                    end else begin
                        cnt_d      = cnt_q + IdxOne;
                        out_data_d = {3'd3, limb_ext};
                    end
                end
            end
            StStart: begin
                if (xfer) begin
                    state_d    = StEos;
                    out_data_d = '0;
                end
            end
            StEos: begin
                state_d   = StIdle;
                packets_d = packets_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase

        if (enter_limbs) begin
            if (nlimbs_q == '0) begin
                state_d    = StStart;
                out_data_d = {3'd4, 29'd0};
            end else begin
                state_d    = StReal;
                cnt_d      = '0;
                out_data_d = {3'd2, limb_ext};
            end
        end

        out_valid_d = (state_d == StAddr) || (state_d == StZoom) || (state_d == StReal) ||
                      (state_d == StImag) || (state_d == StStart);
        eos_d       = (state_d == StEos);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            nlimbs_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            eos_q       <= 1'b0;
            packets_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nlimbs_q    <= nlimbs_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            eos_q       <= eos_d;
            packets_q   <= packets_d;
        end
    end

    assign out_data          = out_data_q;
    assign out_valid         = out_valid_q;
    assign out_end_of_stream = eos_q;
    assign packets_sent      = packets_q;

endmodule

// File: tb/tb_tile_packet_encoder.sv
// Self-checking bench for tile_packet_encoder: directed and randomized jobs compared
// against a queue-based packet model built from the limb store contents.
module tb_tile_packet_encoder;
`ifdef TILE_ENC_ZOOM_EN
    localparam int ZW = 1;
`else
    localparam int ZW = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_re = 1'b0, wr_im = 1'b0;
    logic [5:0]  wr_idx = '0;
    logic [26:0] wr_data = '0;
    logic [28:0] j_addr = '0, j_zoom = '0;
    logic [6:0]  j_n = '0;
    logic        j_valid = 1'b0;
    logic        j_ready;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        o_eos;
    logic [15:0] pk_sent;

    tile_packet_encoder dut (
        .clock            (clk),
        .reset            (rst_n),
        .limb_wr_real_en  (wr_re),
        .limb_wr_imag_en  (wr_im),
        .limb_wr_index    (wr_idx),
        .limb_wr_data     (wr_data),
        .job_addr         (j_addr),
        .job_zoom         (j_zoom),
        .job_num_limbs    (j_n),
        .job_valid        (j_valid),
        .job_ready        (j_ready),
        .out_data         (o_data),
        .out_valid        (o_valid),
        .out_ready        (o_ready),
        .out_end_of_stream(o_eos),
        .packets_sent     (pk_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [26:0] m_real [64];
    logic [26:0] m_imag [64];
    logic [15:0] exp_packets = '0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] rnd_limb();
        return 27'($urandom() & 32'h07FF_FFFF);
    endfunction

    // Called at #1 after an edge while the encoder is idle.
    task automatic write_limb(input bit re, input bit im, input int idx, input logic [26:0] d);
        wr_re = re; wr_im = im; wr_idx = 6'(idx); wr_data = d;
        @(posedge clk); #1;
        wr_re = 1'b0; wr_im = 1'b0;
        if (re) m_real[idx] = d;
        if (im) m_imag[idx] = d;
    endtask

    // mode 0: ready always high, 1: toggles 1010..., 2: random
    task automatic run_packet(input string tag, input logic [28:0] addr, input logic [28:0] zoom,
                              input int n, input int mode, input bit intrude);
        bit          eos_seen = 1'b0;
        bit          stalled = 1'b0;
        logic [31:0] held = '0;
        logic [31:0] w;
        int          bubbles = 0;
        int          cyc = 0;
        exp_q.delete();
        got_q.delete();
        exp_q.push_back({3'd0, addr});
        if (ZW == 1) exp_q.push_back({3'd1, zoom});
        for (int i = 0; i < n; i++) exp_q.push_back({3'd2, 2'b00, m_real[i]});
        for (int i = 0; i < n; i++) exp_q.push_back({3'd3, 2'b00, m_imag[i]});
        exp_q.push_back(32'h8000_0000);

        check({tag, "/ready_idle"}, 32'(j_ready), 32'd1);
        j_addr = addr; j_zoom = zoom; j_n = 7'(n); j_valid = 1'b1;
        @(posedge clk); #1;
        j_valid = 1'b0;
        while (!eos_seen && cyc < 3000) begin
            case (mode)
                0: o_ready = 1'b1;
                1: o_ready = (cyc % 2 == 0);
                default: o_ready = 1'($urandom_range(0, 1));
            endcase
            if (intrude && cyc == 2) begin
                check({tag, "/ready_busy"}, 32'(j_ready), 32'd0);
                wr_re = 1'b1; wr_im = 1'b1; wr_idx = 6'd0; wr_data = ~m_real[0];
                j_valid = 1'b1; j_addr = 29'h0ABC_DEF; j_n = 7'd1;
            end
            if (intrude && cyc == 3) begin
                wr_re = 1'b0; wr_im = 1'b0; j_valid = 1'b0;
            end
            if (stalled) check({tag, "/stall_stable"}, o_data, held);
            if (o_eos) begin
                eos_seen = 1'b1;
                check({tag, "/eos_valid_low"}, 32'(o_valid), 32'd0);
            end else if (!o_valid) begin
                bubbles++;
            end
            if (o_valid && o_ready) got_q.push_back(o_data);
            stalled = o_valid && !o_ready;
            held = o_data;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "/eos_seen"}, 32'(eos_seen), 32'd1);
        if (mode == 0) check({tag, "/bubbles"}, 32'(bubbles), 32'd0);
        check({tag, "/word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            w = (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx;
            check($sformatf("%s/word%0d", tag, i), w, exp_q[i]);
        end
        exp_packets = exp_packets + 16'd1;
        check({tag, "/eos_one_cycle"}, 32'(o_eos), 32'd0);
        check({tag, "/ready_after"}, 32'(j_ready), 32'd1);
        check({tag, "/packets_sent"}, 32'(pk_sent), 32'(exp_packets));
    endtask

    initial begin
        int xfers;
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        check("rst/out_valid", 32'(o_valid), 32'd0);
        check("rst/out_data", o_data, 32'd0);
        check("rst/eos", 32'(o_eos), 32'd0);
        check("rst/packets", 32'(pk_sent), 32'd0);
        check("rst/job_ready", 32'(j_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 64; i++) write_limb(1'b1, 1'b0, i, rnd_limb());
        for (int i = 0; i < 64; i++) write_limb(1'b0, 1'b1, i, rnd_limb());
        for (int i = 0; i < 3; i++) begin
            write_limb(1'b1, 1'b0, i, 27'(i + 1));
            write_limb(1'b0, 1'b1, i, 27'(i + 4));
        end

        // Abort mid-IMAG with reset; count was zero before this packet.
        o_ready = 1'b1;
        j_addr = 29'h10; j_zoom = 29'h7; j_n = 7'd3; j_valid = 1'b1;
        @(posedge clk); #1;
        j_valid = 1'b0;
        xfers = 0;
        cyc = 0;
        while (xfers < 1 + ZW + 3 && cyc < 50) begin
            if (o_valid && o_ready) xfers++;
            @(posedge clk); #1;
            cyc++;
        end
        check("abort/in_imag", o_data, 32'h6000_0004);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort/out_valid", 32'(o_valid), 32'd0);
        check("abort/eos", 32'(o_eos), 32'd0);
        check("abort/job_ready", 32'(j_ready), 32'd1);
        check("abort/packets", 32'(pk_sent), 32'd0);
        check("abort/out_data", o_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort/no_eos_after", 32'(o_eos), 32'd0);
        check("abort/valid_after", 32'(o_valid), 32'd0);

        run_packet("basic", 29'h10, 29'h7, 3, 0, 1'b0);
        run_packet("toggle", 29'h10, 29'h7, 3, 1, 1'b0);
        run_packet("n0", 29'h1234, 29'h55, 0, 0, 1'b0);
        run_packet("intrude", 29'h0F0F, 29'h3, 3, 0, 1'b1);
        run_packet("old_limbs", 29'h10, 29'h7, 3, 0, 1'b0);
        run_packet("nmax", 29'h1FFF_FFFF, 29'h1, 64, 2, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int nw = $urandom_range(0, 4);
            for (int j = 0; j < nw; j++) begin
                int sel = $urandom_range(0, 2);
                write_limb(sel != 1, sel != 0, $urandom_range(0, 63), rnd_limb());
            end
            run_packet($sformatf("rand%0d", k), 29'($urandom()), 29'($urandom()),
                       $urandom_range(0, 64), $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
